// File: rtl/filtro_pkg.sv
// Shared definitions for the accumulator datapath and its serial receiver:
// default sample format, saturation limits and the serializer state encoding.
package filtro_pkg;

  localparam int unsigned N_DEF = 25;
  localparam int unsigned F_DEF = 12;

  localparam logic [N_DEF-1:0] SAT_POS_DEF = {1'b0, {(N_DEF-1){1'b1}}};
  localparam logic [N_DEF-1:0] SAT_NEG_DEF = {1'b1, {(N_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } estado_t;

endpackage

// File: rtl/fifo_muestras.sv
// Synchronous sample FIFO with same-cycle push/pop; DEPTH must be a power of two.
module fifo_muestras
#(
  parameter int unsigned W     = 25,
  parameter int unsigned DEPTH = 4
)(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] dato_c,
  output logic         lleno_c,
  output logic         vacio_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          wr_en;
  logic          rd_en;

  assign lleno_c = (cnt_q == CW'(DEPTH));
  assign vacio_c = (cnt_q == '0);
  assign dato_c  = mem[rd_q];

  // A write into a full FIFO is only legal when the head leaves in the same cycle.
  assign rd_en = pop & ~vacio_c;
  assign wr_en = push & (~lleno_c | rd_en);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (rd_en) rd_q <= rd_q + AW'(1);
      if (wr_en && !rd_en)      cnt_q <= cnt_q + CW'(1);
      else if (rd_en && !wr_en) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q] <= wdata;
  end

endmodule

// File: rtl/receptor_acumulado.sv
// Accumulator receiver: rescales 2N-bit updates to N-bit samples, queues them and
// shifts them MSB-first to the DAC. Define RECEPTOR_SAT_EN to saturate instead of wrap.
module receptor_acumulado
  import filtro_pkg::*;
#(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned F        = F_DEF,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned SCLK_DIV = 2
)(
  input  logic           clk,
  input  logic           reset_n,
  input  logic [2*N-1:0] In_acum,
  input  logic           Signal_in,
  output logic           sclk,
  output logic           cs_n,
  output logic           sdo,
  output logic           busy,
  output logic           sat,
  output logic           perdida
);

  localparam int unsigned W  = 2 * N;
  localparam int unsigned CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  logic [N-1:0] muestra_c;
  logic         unused_bits;

`ifdef RECEPTOR_SAT_EN
  localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_NEG = {1'b1, {(N-1){1'b0}}};

  logic ovf_c;

  // Overflow when the discarded integer bits are not a sign extension of the sample.
  assign ovf_c       = (In_acum[W-1:N+F] != {(N-F){In_acum[N+F-1]}});
  assign muestra_c   = !ovf_c ? In_acum[N+F-1:F] : (In_acum[W-1] ? SAT_NEG : SAT_POS);
  assign unused_bits = ^In_acum[F-1:0];
`else
  assign muestra_c   = In_acum[N+F-1:F];
  assign unused_bits = ^{In_acum[W-1:N+F], In_acum[F-1:0]};
`endif

  logic [N-1:0] dato_c;
  logic         lleno_c;
  logic         vacio_c;
  logic         pop_c;
  logic         acepta_c;

  fifo_muestras #(
    .W     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (acepta_c),
    .wdata   (muestra_c),
    .pop     (pop_c),
    .dato_c  (dato_c),
    .lleno_c (lleno_c),
    .vacio_c (vacio_c)
  );

  estado_t       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          fase_q, fase_d;
  logic [N-1:0]  sreg_q, sreg_d;
  logic          sclk_q, sclk_d;
  logic          cs_n_q, cs_n_d;
  logic          sdo_q, sdo_d;
  logic          busy_q, busy_d;
  logic          sat_q, sat_d;
  logic          perdida_q, perdida_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      fase_q    <= 1'b0;
      sreg_q    <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      sdo_q     <= 1'b0;
      busy_q    <= 1'b0;
      sat_q     <= 1'b0;
      perdida_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      fase_q    <= fase_d;
      sreg_q    <= sreg_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      sdo_q     <= sdo_d;
      busy_q    <= busy_d;
      sat_q     <= sat_d;
      perdida_q <= perdida_d;
    end
  end

  // Serializer: every phase lasts SCLK_DIV cycles; in IDLE busy_q marks a pending guard.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    fase_d    = fase_q;
    sreg_d    = sreg_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    sdo_d     = sdo_q;
    busy_d    = busy_q;
    pop_c     = 1'b0;
    acepta_c  = 1'b0;
    perdida_d = 1'b0;
    sat_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (busy_q && (cnt_q != DIV_LAST)) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          if (vacio_c) begin
            busy_d = 1'b0;
          end else begin
            pop_c  = 1'b1;
            state_d = SETUP;
            cs_n_d = 1'b0;
            busy_d = 1'b1;
            sreg_d = dato_c;
            sdo_d  = dato_c[N-1];
          end
        end
      end

      SETUP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          fase_d  = 1'b0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!fase_q) begin
            sclk_d = 1'b1;
            fase_d = 1'b1;
          end else begin
            // Falling edge: present the next bit; zeros fill in behind the MSB.
            sclk_d = 1'b0;
            fase_d = 1'b0;
            sreg_d = {sreg_q[N-2:0], 1'b0};
            sdo_d  = sreg_q[N-2];
            if (bit_q == BIT_LAST) state_d = HOLD;
            else                   bit_d   = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    acepta_c  = Signal_in & (~lleno_c | pop_c);
    perdida_d = Signal_in & ~acepta_c;
`ifdef RECEPTOR_SAT_EN
    sat_d     = acepta_c & ovf_c;
`endif
  end

  assign sclk    = sclk_q;
  assign cs_n    = cs_n_q;
  assign sdo     = sdo_q;
  assign busy    = busy_q;
  assign sat     = sat_q;
  assign perdida = perdida_q;

endmodule

// File: tb/tb_receptor_acumulado.sv
// Directed bench for receptor_acumulado: rescale/saturation patterns, frame timing,
// FIFO overflow and mid-frame reset. Expectations follow RECEPTOR_SAT_EN.
`timescale 1ns/1ps
module tb_receptor_acumulado;

  localparam int unsigned N        = 25;
  localparam int unsigned F        = 12;
  localparam int unsigned W        = 2 * N;
  localparam int unsigned SCLK_DIV = 2;
  localparam int unsigned FRAME    = SCLK_DIV * (2 * N + 2);

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] In_acum;
  logic         Signal_in;
  logic         sclk, cs_n, sdo, busy, sat, perdida;

  int n_cmp = 0;
  int n_err = 0;

  receptor_acumulado #(
    .N        (N),
    .F        (F),
    .DEPTH    (4),
    .SCLK_DIV (SCLK_DIV)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .In_acum   (In_acum),
    .Signal_in (Signal_in),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .sdo       (sdo),
    .busy      (busy),
    .sat       (sat),
    .perdida   (perdida)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe; returns at the sample point right after the strobe edge.
  task automatic strobe(input logic [W-1:0] v);
    In_acum   = v;
    Signal_in = 1'b1;
    tick();
    Signal_in = 1'b0;
  endtask

  // Waits for cs_n to fall, then collects the bits sampled at each sclk rise.
  task automatic recibir(output logic [N-1:0] d, output int bajo, output int subidas,
                         output int inestable, output int espera, output bit to);
    logic prev_sclk;
    logic prev_sdo;
    d = '0; bajo = 0; subidas = 0; inestable = 0; espera = 0; to = 1'b0;
    while (cs_n === 1'b1 && espera < 400) begin
      tick();
      espera++;
    end
    if (cs_n !== 1'b0) begin
      to = 1'b1;
      return;
    end
    prev_sclk = sclk;
    prev_sdo  = sdo;
    while (cs_n === 1'b0 && bajo < 400) begin
      bajo++;
      if (sclk === 1'b1 && prev_sclk === 1'b0) begin
        subidas++;
        d = {d[N-2:0], sdo};
        if (sdo !== prev_sdo) inestable++;
      end
      prev_sclk = sclk;
      prev_sdo  = sdo;
      tick();
    end
    if (cs_n !== 1'b1) to = 1'b1;
  endtask

  task automatic test_reset();
    int activos;
    reset_n   = 1'b0;
    Signal_in = 1'b0;
    In_acum   = '0;
    repeat (3) tick();
    n_cmp++;
    if ({sclk, cs_n, sdo, busy, sat, perdida} !== 6'b010000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 010000", {sclk, cs_n, sdo, busy, sat, perdida});
    end
    strobe(W'(4096));
    n_cmp++;
    if ({sclk, cs_n, sdo, busy, sat, perdida} !== 6'b010000) begin
      n_err++;
      $display("FAIL reset_strobe: got %b expected 010000", {sclk, cs_n, sdo, busy, sat, perdida});
    end
    reset_n = 1'b1;
    activos = 0;
    repeat (20) begin
      tick();
      if (cs_n !== 1'b1 || busy !== 1'b0) activos++;
    end
    n_cmp++;
    if (activos != 0) begin
      n_err++;
      $display("FAIL reset_strobe_ignored: got %0d active cycles expected 0", activos);
    end
  endtask

  task automatic test_rescale();
    logic [W-1:0] tv_in  [7];
    logic [N-1:0] tv_sat [7];
    logic [N-1:0] tv_wrp [7];
    logic         tv_ovf [7];
    logic [N-1:0] exp_d;
    logic         exp_sat;
    logic [N-1:0] d;
    int bajo, sub, inest, esp;
    bit to;
    tv_in[0] = W'(4096);             tv_sat[0] = 25'h0000001; tv_wrp[0] = 25'h0000001; tv_ovf[0] = 1'b0;
    tv_in[1] = W'(1) << 40;          tv_sat[1] = 25'h0FFFFFF; tv_wrp[1] = 25'h0000000; tv_ovf[1] = 1'b1;
    tv_in[2] = W'(0) - (W'(1) << 40); tv_sat[2] = 25'h1000000; tv_wrp[2] = 25'h0000000; tv_ovf[2] = 1'b1;
    tv_in[3] = W'(0) - W'(4096);     tv_sat[3] = 25'h1FFFFFF; tv_wrp[3] = 25'h1FFFFFF; tv_ovf[3] = 1'b0;
    tv_in[4] = 50'h00_0ABC_DEF0_00;   tv_sat[4] = 25'h0ABCDEF; tv_wrp[4] = 25'h0ABCDEF; tv_ovf[4] = 1'b0;
    tv_in[5] = 50'h00_0FFF_FFF0_00;   tv_sat[5] = 25'h0FFFFFF; tv_wrp[5] = 25'h0FFFFFF; tv_ovf[5] = 1'b0;
    tv_in[6] = 50'h00_1000_0000_00;   tv_sat[6] = 25'h0FFFFFF; tv_wrp[6] = 25'h1000000; tv_ovf[6] = 1'b1;
    for (int i = 0; i < 7; i++) begin
`ifdef RECEPTOR_SAT_EN
      exp_d   = tv_sat[i];
      exp_sat = tv_ovf[i];
`else
      exp_d   = tv_wrp[i];
      exp_sat = 1'b0;
`endif
      strobe(tv_in[i]);
      n_cmp++;
      if ({sat, perdida} !== {exp_sat, 1'b0}) begin
        n_err++;
        $display("FAIL rescale_flags[%0d]: got sat/perdida %b expected %b", i, {sat, perdida}, {exp_sat, 1'b0});
      end
      tick();
      n_cmp++;
      if ({cs_n, busy, sat} !== 3'b010) begin
        n_err++;
        $display("FAIL rescale_start[%0d]: got cs_n/busy/sat %b expected 010", i, {cs_n, busy, sat});
      end
      recibir(d, bajo, sub, inest, esp, to);
      n_cmp++;
      if (to || d !== exp_d) begin
        n_err++;
        $display("FAIL rescale_data[%0d]: got %h (timeout %0d) expected %h", i, d, to, exp_d);
      end
      n_cmp++;
      if (bajo != int'(FRAME) || sub != int'(N) || inest != 0) begin
        n_err++;
        $display("FAIL rescale_timing[%0d]: got low %0d rises %0d unstable %0d expected %0d %0d 0",
                 i, bajo, sub, inest, FRAME, N);
      end
      n_cmp++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL rescale_guard_busy[%0d]: got %b expected 1", i, busy);
      end
      tick();
      tick();
      n_cmp++;
      if (busy !== 1'b0) begin
        n_err++;
        $display("FAIL rescale_idle[%0d]: got busy %b expected 0", i, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]   perd;
    logic [N-1:0] d;
    int bajo, sub, inest, esp, activos;
    bit to;
    perd = '0;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          In_acum   = W'(k + 1) << F;
          Signal_in = 1'b1;
          tick();
          perd[k]   = perdida;
        end
        Signal_in = 1'b0;
      end
      begin
        for (int k = 0; k < 5; k++) begin
          recibir(d, bajo, sub, inest, esp, to);
          n_cmp++;
          if (to || d !== N'(k + 1) || bajo != int'(FRAME)) begin
            n_err++;
            $display("FAIL b2b_frame[%0d]: got %h low %0d (timeout %0d) expected %h low %0d",
                     k, d, bajo, to, N'(k + 1), FRAME);
          end
          if (k > 0) begin
            n_cmp++;
            if (esp < int'(SCLK_DIV)) begin
              n_err++;
              $display("FAIL b2b_gap[%0d]: got %0d cycles expected >= %0d", k, esp, SCLK_DIV);
            end
          end
        end
      end
    join
    n_cmp++;
    if (perd !== 6'b100000) begin
      n_err++;
      $display("FAIL b2b_perdida: got %b expected 100000", perd);
    end
    activos = 0;
    repeat (150) begin
      tick();
      if (cs_n !== 1'b1) activos++;
    end
    n_cmp++;
    if (activos != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_no_extra: got %0d low cycles busy %b expected 0 0", activos, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] d;
    logic prev;
    int sub, guard, activos, bajo, s2, inest, esp;
    bit to;
    strobe(W'(7) << F);
    strobe(W'(8) << F);
    strobe(W'(9) << F);
    sub   = 0;
    guard = 0;
    prev  = sclk;
    while (sub < 10 && guard < 400) begin
      tick();
      guard++;
      if (sclk === 1'b1 && prev === 1'b0) sub++;
      prev = sclk;
    end
    reset_n = 1'b0;
    tick();
    n_cmp++;
    if ({cs_n, sclk, busy, sat, perdida} !== 5'b10000 || sub != 10) begin
      n_err++;
      $display("FAIL reset_abort: got cs_n/sclk/busy/sat/perdida %b after %0d rises expected 10000 after 10",
               {cs_n, sclk, busy, sat, perdida}, sub);
    end
    reset_n = 1'b1;
    activos = 0;
    repeat (300) begin
      tick();
      if (cs_n !== 1'b1 || busy !== 1'b0) activos++;
    end
    n_cmp++;
    if (activos != 0) begin
      n_err++;
      $display("FAIL reset_flush: got %0d active cycles expected 0", activos);
    end
    strobe(W'(25'h0155555) << F);
    recibir(d, bajo, s2, inest, esp, to);
    n_cmp++;
    if (to || d !== 25'h0155555) begin
      n_err++;
      $display("FAIL reset_recover: got %h (timeout %0d) expected 0155555", d, to);
    end
  endtask

  initial begin
    test_reset();
    test_rescale();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/receptor_acumulado.md
# receptor_acumulado

Consumer end of the accumulator update interface. The block takes the 2N-bit accumulated value and its one-cycle "value changed" strobe and rescales each update to an N-bit fixed-point sample, saturating on overflow. Samples are queued in a small FIFO and shifted out MSB-first on a 3-wire serial link (sclk, cs_n, sdo) toward the DAC. It sits between the accumulator stage and the converter output pins.

## Interface
- N, 25: output sample width; input is 2N bits.
- F, 12: fractional bits of the output sample; the input carries 2F fractional bits.
- DEPTH, 4: FIFO entries, power of two, ≥2.
- SCLK_DIV, 2: sclk half-period in clk cycles, ≥1.

- clk  input  1  single clock, all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- In_acum  input  2N  accumulated value, two's complement.
- Signal_in  input  1  one-cycle strobe; In_acum is valid and new in that cycle.
- sclk  output  1  serial clock, idles low.
- cs_n  output  1  frame select, active low.
- sdo  output  1  serial data, MSB first.
- busy  output  1  high while a frame is in progress (cs_n low or guard time).
- sat  output  1  one-cycle pulse: the accepted update was saturated.
- perdida  output  1  one-cycle pulse: update dropped, FIFO full.

## Operation
- Rescale: sample = In_acum[N+F-1:F]. Overflow exists when In_acum[2N-1:N+F] is not all equal to In_acum[N+F-1]. On overflow the sample is 2^(N-1)-1 if In_acum[2N-1]=0, else -2^(N-1).
- Write: Signal_in=1 writes the sample if the FIFO is not full, or if it is full and a pop occurs in the same cycle. Otherwise the update is dropped and perdida pulses.
- FSM states:
  - IDLE: cs_n=1, sclk=0. If FIFO non-empty and the guard time has elapsed, pop into the shift register and go to SETUP.
  - SETUP: cs_n=0, sdo=bit N-1, held SCLK_DIV cycles, then go to SHIFT.
  - SHIFT: N sclk periods. sclk rises after SCLK_DIV cycles, falls after SCLK_DIV more; sdo advances on each falling edge. After the N-th falling edge, go to HOLD.
  - HOLD: cs_n=0 for SCLK_DIV cycles, then cs_n=1 and go to IDLE. IDLE enforces a guard of SCLK_DIV cycles with cs_n high before the next pop.
- busy=1 from the pop until the guard time ends.

## Timing
- Reset values: sclk=0, cs_n=1, sdo=0, busy=0, sat=0, perdida=0; FIFO empty; FSM in IDLE; guard satisfied.
- Strobe at edge t: sample is in the FIFO after edge t. If IDLE and the FIFO was empty, the pop happens at edge t+1, and cs_n=0 and busy=1 are visible after edge t+1.
- sat and perdida are registered and assert in the cycle after the strobe.
- Frame length from cs_n fall to cs_n rise: SCLK_DIV·(2N+2) cycles. Minimum frame spacing adds SCLK_DIV cycles.
- Back-to-back strobes every cycle are legal; only FIFO capacity limits them.
- Reset asserted mid-frame: after that edge, cs_n=1 and sclk=0. The partial frame is aborted and the FIFO is flushed.
- Strobe during reset: ignored.

## Configuration
- RECEPTOR_SAT_EN defined: saturation as described; sat pulses on each saturated update.
- RECEPTOR_SAT_EN undefined: plain truncation (wrap-around) of In_acum[N+F-1:F]; sat is tied to 0.

## Structure
- Shared package filtro_pkg holds:
  - FSM state encoding (IDLE, SETUP, SHIFT, HOLD).
  - Default N/F constants shared with the accumulator.
  - The saturation-limit constants.
- Sub-module fifo_muestras: synchronous FIFO with DEPTH×N storage, full/empty flags, and same-cycle push/pop. Everything else stays in receptor_acumulado.

## Test plan
- Rescale: In_acum=4096 with strobe → one frame, sdo bits = 25'h0000001; sat=0.
- Positive overflow: In_acum=2^40 → frame 25'h0FFFFFF, sat pulses once. Without RECEPTOR_SAT_EN → 25'h0000000, sat=0.
- Negative overflow: In_acum=-(2^40) → frame 25'h1000000, sat pulses once.
- Overflow: 6 strobes on consecutive cycles from IDLE, DEPTH=4 → exactly one perdida pulse (6th strobe); 5 frames emitted in order with guard gaps of ≥2 cycles.
- Frame timing: SCLK_DIV=2, one strobe → cs_n low for exactly 104 cycles; 25 sclk rising edges; sdo stable across each rising edge.
- Reset mid-frame: assert reset_n=0 at bit 10 of a frame with 2 queued → cs_n=1 next cycle. After release, no frame starts without a new strobe.
